sharp_pixel_writer: RTL and testbench

Write-back end of the image-sharpening datapath. It accepts a stream of sharpened 8-bit pixels over a valid/ready handshake and packs them little-endian into 32-bit words. It writes each word to DLX data memory at incrementing word addresses over a req/ack bus. It is the counterpart of the pixel fetch path: the fetch side reads source words and unpacks them, this block packs result pixels and writes them.

---
 rtl/sharp_pkg.sv | 17 +
 rtl/pixel_packer.sv | 37 +++
 rtl/sharp_pixel_writer.sv | 123 ++++++++++++
 tb/tb_sharp_pixel_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sharp_pkg.sv
// Shared definitions for the image-sharpening write-back path:
// pixel geometry and the writer state encoding.
package sharp_pkg;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs incoming pixels little-endian into one memory word.
// Tracks which lanes have been filled.
module pixel_packer
    import sharp_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    clear,
    input  logic [PIX_W-1:0]        din,
    output logic [WORD_W-1:0]       word,
    output logic [PIX_PER_WORD-1:0] be,
    output logic                    full
);

    logic [PIX_PER_WORD-1:0][PIX_W-1:0] lanes;
    logic [LANE_W-1:0]                  lane_idx;

    // Lane index wraps to 0 after the last lane, matching the cleared state.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lanes    <= '0;
            be       <= '0;
            lane_idx <= '0;
        end else if (load) begin
            lanes[lane_idx] <= din;
            be[lane_idx]    <= 1'b1;
            lane_idx        <= lane_idx + 1'b1;
        end
    end

    assign word = lanes;

    // High when the next load completes the word.
    assign full = (lane_idx == LANE_W'(PIX_PER_WORD - 1));

endmodule

// File: rtl/sharp_pixel_writer.sv
// Write-back end of the sharpening datapath: collects result pixels,
// packs them into words and writes them to data memory at rising addresses.
module sharp_pixel_writer
    import sharp_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [15:0]             num_pix,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    pix_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    output logic [PIX_PER_WORD-1:0] mem_be,
    input  logic                    mem_ack,
    output logic                    busy,
    output logic                    done
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       remaining;
    logic              pack_load;
    logic              pack_clear;
    logic              pack_full;
    logic              xfer;
    logic              launch;

    assign xfer   = (state == COLLECT) && pix_valid;
    assign launch = (state == IDLE) && start && (num_pix != 16'd0);

    pixel_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .load  (pack_load),
        .clear (pack_clear),
        .din   (pix_data),
        .word  (mem_wdata),
        .be    (mem_be),
        .full  (pack_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pix_ready  = 1'b0;
        mem_req    = 1'b0;
        pack_load  = 1'b0;
        pack_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_pix == 16'd0) begin
                        next_state = DONE;
                    end else begin
                        pack_clear = 1'b1;
                        next_state = COLLECT;
                    end
                end
            end
            COLLECT: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    pack_load = 1'b1;
                    // remaining is still pre-decrement here, so 1 means last pixel.
                    if (pack_full || remaining == 16'd1) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pack_clear = 1'b1;
                    next_state = (remaining == 16'd0) ? DONE : COLLECT;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address is forced word-aligned at launch and wraps silently on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            remaining <= '0;
        end else if (launch) begin
            addr_q    <= base_addr & ~ADDR_W'(3);
            remaining <= num_pix;
        end else begin
            if (xfer) begin
                remaining <= remaining - 16'd1;
            end
            if (state == WRITE && mem_ack) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
        end
    end

    assign mem_we   = mem_req;
    assign mem_addr = addr_q;
    assign busy     = (state == COLLECT) || (state == WRITE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_sharp_pixel_writer.sv
// Directed bench for sharp_pixel_writer: a job table with expected memory
// writes, plus hand sequences for zero-length jobs, ignored start and reset.
module tb_sharp_pixel_writer;

    typedef struct packed {
        logic [31:0]      base;
        logic [15:0]      num;
        logic [7:0]       ackDelay;
        logic             toggle;
        logic [1:0]       nWrites;
        logic [1:0][31:0] expAddr;
        logic [1:0][31:0] expData;
        logic [1:0][3:0]  expBe;
        logic [3:0]       expReqLen;
    } jobVec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_pix = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;

    int testsRun = 0;
    int testsFailed = 0;

    int ackDelay = 0;
    bit srcToggle = 1'b0;
    int srcCount = 0;
    int pixIdx = 0;
    bit phase = 1'b0;
    bit xferPending = 1'b0;
    int xferCount = 0;
    int doneCount = 0;
    int bothErr = 0;
    int curLen = 0;
    int stableErr = 0;
    int weErr = 0;
    int readyInWrite = 0;
    int writeCount = 0;
    logic [31:0] holdA, holdD;
    logic [3:0]  holdB;
    logic [31:0] logAddr [8];
    logic [31:0] logData [8];
    logic [3:0]  logBe   [8];
    int          logLen  [8];

    jobVec_t jobs [7];

    sharp_pixel_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_pix   (num_pix),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pixVal(input int i);
        return 8'((i + 1) * 17);
    endfunction

    // Pixel source and status monitor, evaluated away from the rising edge.
    always @(negedge clk) begin
        if (xferPending) begin
            xferCount++;
            pixIdx++;
        end
        phase     = ~phase;
        pix_valid = (!srcToggle || phase) && (pixIdx < srcCount);
        pix_data  = pixVal(pixIdx);
        xferPending = pix_valid && pix_ready;
        if (busy && done) bothErr++;
        if (done) doneCount++;
    end

    // Memory responder: acks after ackDelay wait cycles and logs each write.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_we !== mem_req) weErr++;
        if (mem_req) begin
            if (curLen == 0) begin
                holdA = mem_addr;
                holdD = mem_wdata;
                holdB = mem_be;
            end else if (mem_addr !== holdA || mem_wdata !== holdD || mem_be !== holdB) begin
                stableErr++;
            end
            if (pix_ready) readyInWrite++;
            curLen++;
            if (curLen > ackDelay) begin
                mem_ack = 1'b1;
                if (writeCount < 8) begin
                    logAddr[writeCount] = mem_addr;
                    logData[writeCount] = mem_wdata;
                    logBe[writeCount]   = mem_be;
                    logLen[writeCount]  = curLen;
                end
                writeCount++;
                curLen = 0;
            end
        end else begin
            curLen = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearCounters();
        xferCount = 0; doneCount = 0; bothErr = 0; stableErr = 0;
        weErr = 0; readyInWrite = 0; writeCount = 0; pixIdx = 0;
    endtask

    task automatic applyStimulus(input int j, input jobVec_t v);
        ackDelay  = int'(v.ackDelay);
        srcToggle = v.toggle;
        srcCount  = int'(v.num);
        clearCounters();
        start     = 1'b1;
        base_addr = v.base;
        num_pix   = v.num;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300 && doneCount == 0; c++) tick();
        repeat (4) tick();
        checkOutput($sformatf("job%0d done pulses", j), doneCount, 1);
        checkOutput($sformatf("job%0d write count", j), writeCount, 32'(v.nWrites));
        checkOutput($sformatf("job%0d transfers", j), xferCount, 32'(v.num));
        checkOutput($sformatf("job%0d write held stable", j), stableErr, 0);
        checkOutput($sformatf("job%0d ready during write", j), readyInWrite, 0);
        checkOutput($sformatf("job%0d we tracks req", j), weErr, 0);
        checkOutput($sformatf("job%0d busy and done", j), bothErr, 0);
        checkOutput($sformatf("job%0d busy after done", j), busy, 0);
        for (int w = 0; w < 2; w++) begin
            if (w < int'(v.nWrites) && w < writeCount) begin
                checkOutput($sformatf("job%0d addr%0d", j, w), logAddr[w], v.expAddr[w]);
                checkOutput($sformatf("job%0d data%0d", j, w), logData[w], v.expData[w]);
                checkOutput($sformatf("job%0d be%0d", j, w), 32'(logBe[w]), 32'(v.expBe[w]));
                checkOutput($sformatf("job%0d req len%0d", j, w), logLen[w], 32'(v.expReqLen));
            end
        end
    endtask

    function automatic jobVec_t mkJob(input logic [31:0] base, input logic [15:0] num,
                                      input logic [7:0] dly, input logic tog, input logic [1:0] nw,
                                      input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                                      input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                                      input logic [3:0] rl);
        jobVec_t v;
        v.base = base; v.num = num; v.ackDelay = dly; v.toggle = tog; v.nWrites = nw;
        v.expAddr[0] = a0; v.expData[0] = d0; v.expBe[0] = b0;
        v.expAddr[1] = a1; v.expData[1] = d1; v.expBe[1] = b1;
        v.expReqLen = rl;
        return v;
    endfunction

    initial begin
        jobs[0] = mkJob(32'h1000, 16'd8, 8'd0, 1'b0, 2'd2,
                        32'h1000, 32'h44332211, 4'hF, 32'h1004, 32'h88776655, 4'hF, 4'd1);
        jobs[1] = mkJob(32'h1000, 16'd6, 8'd0, 1'b0, 2'd2,
                        32'h1000, 32'h44332211, 4'hF, 32'h1004, 32'h00006655, 4'h3, 4'd1);
        jobs[2] = mkJob(32'h1000, 16'd4, 8'd3, 1'b0, 2'd1,
                        32'h1000, 32'h44332211, 4'hF, 32'h0, 32'h0, 4'h0, 4'd4);
        jobs[3] = mkJob(32'h1000, 16'd5, 8'd0, 1'b1, 2'd2,
                        32'h1000, 32'h44332211, 4'hF, 32'h1004, 32'h00000055, 4'h1, 4'd1);
        jobs[4] = mkJob(32'hFFFFFFFC, 16'd8, 8'd0, 1'b0, 2'd2,
                        32'hFFFFFFFC, 32'h44332211, 4'hF, 32'h00000000, 32'h88776655, 4'hF, 4'd1);
        jobs[5] = mkJob(32'h1003, 16'd2, 8'd1, 1'b0, 2'd1,
                        32'h1000, 32'h00002211, 4'h3, 32'h0, 32'h0, 4'h0, 4'd2);
        jobs[6] = mkJob(32'h1000, 16'd1, 8'd0, 1'b1, 2'd1,
                        32'h1000, 32'h00000011, 4'h1, 32'h0, 32'h0, 4'h0, 4'd1);

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset pix_ready", pix_ready, 0);
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset mem_we", mem_we, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_wdata", mem_wdata, 0);
        checkOutput("reset mem_be", 32'(mem_be), 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);

        for (int j = 0; j < 7; j++) applyStimulus(j, jobs[j]);

        // Zero-length job: done the cycle after start, no memory traffic
        clearCounters();
        srcCount  = 0;
        start     = 1'b1;
        base_addr = 32'h2000;
        num_pix   = 16'd0;
        tick();
        start = 1'b0;
        checkOutput("zero job done", done, 1);
        checkOutput("zero job busy", busy, 0);
        checkOutput("zero job mem_req", mem_req, 0);
        tick();
        checkOutput("zero job done drops", done, 0);
        repeat (3) tick();
        checkOutput("zero job writes", writeCount, 0);
        checkOutput("zero job done pulses", doneCount, 1);

        // Stall a write, try a second start, then reset mid-write
        clearCounters();
        ackDelay  = 1000;
        srcToggle = 1'b0;
        srcCount  = 4;
        start     = 1'b1;
        base_addr = 32'h2000;
        num_pix   = 16'd4;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && !mem_req; c++) tick();
        checkOutput("stall mem_req up", mem_req, 1);
        start     = 1'b1;
        base_addr = 32'h3000;
        num_pix   = 16'd0;
        tick();
        start = 1'b0;
        checkOutput("ignored start busy", busy, 1);
        checkOutput("ignored start done", done, 0);
        checkOutput("ignored start addr", mem_addr, 32'h2000);
        checkOutput("ignored start data", mem_wdata, 32'h44332211);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid reset mem_req", mem_req, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset done", done, 0);
        checkOutput("mid reset mem_addr", mem_addr, 0);
        repeat (5) tick();
        checkOutput("mid reset no done", doneCount, 0);
        checkOutput("mid reset no write", writeCount, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
